// File: rtl/integral_window_ctrl_pkg.sv
// Shared types and width helpers for the integral-image window controller.
// The package is named integral_pkg so other integral-image blocks can share it.
package integral_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } iw_state_e;

    // Column counter width; never collapses to zero bits for degenerate frames.
    function automatic int cw_of(input int frame_width);
        return (frame_width > 1) ? $clog2(frame_width) : 1;
    endfunction

    function automatic int rw_of(input int frame_height);
        return (frame_height > 1) ? $clog2(frame_height) : 1;
    endfunction

endpackage

// File: rtl/integral_window_ctrl_if.sv
// Pixel-in / row-buffer-out bundle of the window controller.
// The master side is the pixel source; the slave side is the controller.
interface integral_window_if
    import integral_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240
);
    localparam int CW = cw_of(FRAME_WIDTH);
    localparam int RW = rw_of(FRAME_HEIGHT);

    logic                  i_frame_start;
    logic                  i_pixel_valid;
    logic [DATA_WIDTH-1:0] i_pixel;
    logic                  o_ready;
    logic                  o_row_wen;
    logic [DATA_WIDTH-1:0] o_fifo_in;
    logic                  o_row_sync;
    logic                  o_window_valid;
    logic [CW-1:0]         o_window_x;
    logic [RW-1:0]         o_window_y;
    logic                  o_frame_done;

    modport master (
        output i_frame_start, i_pixel_valid, i_pixel,
        input  o_ready, o_row_wen, o_fifo_in, o_row_sync,
               o_window_valid, o_window_x, o_window_y, o_frame_done
    );

    modport slave (
        input  i_frame_start, i_pixel_valid, i_pixel,
        output o_ready, o_row_wen, o_fifo_in, o_row_sync,
               o_window_valid, o_window_x, o_window_y, o_frame_done
    );

endinterface

// File: rtl/integral_window_ctrl_counter.sv
// Raster position of the next pixel to be accepted; advances only on accepted pixels.
// Clear has priority over advance so an aborted frame restarts at (0,0).
module pixel_position_counter
    import integral_pkg::*;
#(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    localparam int CW = cw_of(FRAME_WIDTH),
    localparam int RW = rw_of(FRAME_HEIGHT)
) (
    input  logic          clk_os,
    input  logic          reset_os,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          col_last,
    output logic          row_last
);

    localparam logic [CW-1:0] COL_MAX = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(FRAME_HEIGHT - 1);

    assign col_last = (col == COL_MAX);
    assign row_last = (row == ROW_MAX);

    always_ff @(posedge clk_os) begin
        if (reset_os || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                // the frame is over at the last row; wrap rather than run past the bound
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/integral_window_ctrl.sv
// Frame sequencer for the integral-image window: feeds the row-buffer chain and
// flags where a full IWIDTH x IHEIGHT window is available, one cycle after accept.
module integral_window_ctrl
    import integral_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int IWIDTH       = 3,
    parameter int IHEIGHT      = 3
) (
    input  logic               clk_os,
    input  logic               reset_os,
    integral_window_if.slave   bus
);

    localparam int CW = cw_of(FRAME_WIDTH);
    localparam int RW = rw_of(FRAME_HEIGHT);

    localparam logic [CW-1:0] COL_WIN  = CW'(IWIDTH - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(IHEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL = RW'(IHEIGHT - 2);

    iw_state_e             state_q, state_d;
    logic                  ready_q;
    logic                  row_wen_q;
    logic [DATA_WIDTH-1:0] fifo_in_q;
    logic                  row_sync_q;
    logic                  window_valid_q;
    logic [CW-1:0]         window_x_q;
    logic [RW-1:0]         window_y_q;
    logic                  frame_done_q;

    logic          accept;
    logic          take;
    logic          at_frame_end;
    logic          at_fill_end;
    logic          in_window;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;

    // ready_q mirrors FILL/STREAM, so an accept can only happen there.
    assign accept       = bus.i_pixel_valid && ready_q;
    // a frame start in the same cycle restarts the frame and drops the pixel
    assign take         = accept && !bus.i_frame_start;
    assign at_frame_end = col_last && row_last;
    assign at_fill_end  = col_last && (row == ROW_FILL);
    assign in_window    = (col >= COL_WIN) && (row >= ROW_WIN);

    pixel_position_counter #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT)
    ) u_pos (
        .clk_os   (clk_os),
        .reset_os (reset_os),
        .clear    (bus.i_frame_start),
        .advance  (take),
        .col      (col),
        .row      (row),
        .col_last (col_last),
        .row_last (row_last)
    );

    always_comb begin
        state_d = state_q;
        if (bus.i_frame_start) begin
            state_d = ST_FILL;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_FILL: begin
                    if (take && at_frame_end)     state_d = ST_DONE;
                    else if (take && at_fill_end) state_d = ST_STREAM;
                end
                ST_STREAM: begin
                    if (take && at_frame_end)     state_d = ST_DONE;
                end
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state_q        <= ST_IDLE;
            ready_q        <= 1'b0;
            row_wen_q      <= 1'b0;
            fifo_in_q      <= '0;
            row_sync_q     <= 1'b0;
            window_valid_q <= 1'b0;
            window_x_q     <= '0;
            window_y_q     <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ready_q        <= (state_d == ST_FILL) || (state_d == ST_STREAM);
            row_wen_q      <= take;
            row_sync_q     <= take && (col == '0);
            window_valid_q <= take && in_window;
            frame_done_q   <= take && at_frame_end;
            if (take) begin
                fifo_in_q <= bus.i_pixel;
            end
            if (take && in_window) begin
                window_x_q <= col - COL_WIN;
                window_y_q <= row - ROW_WIN;
            end
        end
    end

    assign bus.o_ready        = ready_q;
    assign bus.o_row_wen      = row_wen_q;
    assign bus.o_fifo_in      = fifo_in_q;
    assign bus.o_row_sync     = row_sync_q;
    assign bus.o_window_valid = window_valid_q;
    assign bus.o_window_x     = window_x_q;
    assign bus.o_window_y     = window_y_q;
    assign bus.o_frame_done   = frame_done_q;

endmodule

// File: tb/tb_integral_window_ctrl.sv
// Randomized bench for integral_window_ctrl on an 8x4 frame with a 3x3 window,
// compared every cycle against a frame-index model of the pixel stream.
module tb_integral_window_ctrl;

    localparam int DW = 8;
    localparam int FW = 8;
    localparam int FH = 4;
    localparam int IW = 3;
    localparam int IH = 3;
    localparam int NPIX = FW * FH;
    localparam int VW = 1 + 1 + DW + 1 + 1 + 3 + 2 + 1;

    logic clk_os = 1'b0;
    logic reset_os;
    always #5 clk_os = ~clk_os;

    integral_window_if #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) ifc ();

    integral_window_ctrl #(
        .DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .IWIDTH(IW), .IHEIGHT(IH)
    ) dut (
        .clk_os   (clk_os),
        .reset_os (reset_os),
        .bus      (ifc.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: a frame is "active" from its start until its last pixel; p is the
    // raster index of the next pixel, so col = p % FW and row = p / FW.
    bit          m_active = 0;
    int          m_p = 0;
    logic          m_ready = 0, m_wen = 0, m_sync = 0, m_wv = 0, m_done = 0;
    logic [DW-1:0] m_fifo = '0;
    logic [2:0]    m_x = '0;
    logic [1:0]    m_y = '0;

    function automatic logic [VW-1:0] dut_vec();
        return {ifc.o_ready, ifc.o_row_wen, ifc.o_fifo_in, ifc.o_row_sync,
                ifc.o_window_valid, ifc.o_window_x, ifc.o_window_y, ifc.o_frame_done};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_ready, m_wen, m_fifo, m_sync, m_wv, m_x, m_y, m_done};
    endfunction

    task automatic cycle(input bit st, input bit v, input logic [DW-1:0] px, input bit r);
        bit acc;
        int c, rw;
        reset_os          = r;
        ifc.i_frame_start = st;
        ifc.i_pixel_valid = v;
        ifc.i_pixel       = px;
        @(posedge clk_os);
        if (r) begin
            m_active = 0; m_p = 0;
            {m_ready, m_wen, m_fifo, m_sync, m_wv, m_x, m_y, m_done} = '0;
        end else begin
            acc = v && m_ready;
            m_wen = 0; m_sync = 0; m_wv = 0; m_done = 0;
            if (st) begin
                m_active = 1; m_p = 0;
            end else if (acc) begin
                c = m_p % FW; rw = m_p / FW;
                m_wen = 1; m_fifo = px; m_sync = (c == 0);
                if (c >= IW - 1 && rw >= IH - 1) begin
                    m_wv = 1; m_x = 3'(c - (IW - 1)); m_y = 2'(rw - (IH - 1));
                end
                if (m_p == NPIX - 1) begin
                    m_done = 1; m_active = 0;
                end
                m_p++;
            end
            m_ready = m_active;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(i == 1, 1, 8'hA5, 1);
            vectors++;
            if (dut_vec() !== '0) begin
                miscompares++;
                $display("FAIL reset cyc%0d: got %h want 0", i, dut_vec());
            end
        end
    endtask

    task automatic test_idle_pixels();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 8'($urandom), 0);
            vectors++;
            if (dut_vec() !== model_vec() || ifc.o_row_wen !== 1'b0 || ifc.o_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_pixels cyc%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    // Full frame with no gaps; returns cycles from the start strobe to the first window.
    task automatic run_frame(input string name, output int first_win);
        int nwen, nwv;
        nwen = 0; nwv = 0; first_win = -1;
        cycle(1, 0, '0, 0);
        for (int i = 0; i < NPIX; i++) begin
            cycle(0, 1, 8'($urandom), 0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL %s pix%0d: got %h want %h", name, i, dut_vec(), model_vec());
            end
            nwen += int'(ifc.o_row_wen);
            nwv  += int'(ifc.o_window_valid);
            if (ifc.o_window_valid === 1'b1 && first_win < 0) first_win = i + 1;
            if (i == 18) begin
                vectors++;
                if ({ifc.o_window_valid, ifc.o_window_x, ifc.o_window_y} !== 6'b1_000_00) begin
                    miscompares++;
                    $display("FAIL %s first_window: got v=%b x=%0d y=%0d want v=1 x=0 y=0",
                             name, ifc.o_window_valid, ifc.o_window_x, ifc.o_window_y);
                end
            end
            if (i == NPIX - 1 || i == NPIX - 2) begin
                vectors++;
                if (ifc.o_frame_done !== (i == NPIX - 1)) begin
                    miscompares++;
                    $display("FAIL %s frame_done pix%0d: got %b", name, i, ifc.o_frame_done);
                end
            end
        end
        vectors++;
        if (nwen != NPIX || nwv != 12) begin
            miscompares++;
            $display("FAIL %s counts: got wen=%0d win=%0d want wen=32 win=12", name, nwen, nwv);
        end
    endtask

    task automatic test_continuous_frame();
        int fw;
        run_frame("continuous", fw);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'($urandom), 0);
            vectors++;
            if (dut_vec() !== model_vec() || ifc.o_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL post_frame cyc%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    // Drive one frame with a valid pattern; mode 0 toggles, mode 1 is random.
    task automatic gapped_frame(input string name, input int mode);
        int nwen, ndone, k;
        nwen = 0; ndone = 0; k = 0;
        cycle(1, 0, '0, 0);
        while (m_active && k < 400) begin
            cycle(0, (mode == 0) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0), 8'($urandom), 0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL %s cyc%0d: got %h want %h", name, k, dut_vec(), model_vec());
            end
            nwen  += int'(ifc.o_row_wen);
            ndone += int'(ifc.o_frame_done);
            k++;
        end
        vectors++;
        if (nwen != NPIX || ndone != 1 || k >= 400) begin
            miscompares++;
            $display("FAIL %s totals: got wen=%0d done=%0d cycles=%0d want wen=32 done=1",
                     name, nwen, ndone, k);
        end
    endtask

    task automatic test_abort();
        int ndone;
        ndone = 0;
        cycle(1, 0, '0, 0);
        for (int i = 0; i <= 10; i++) begin
            cycle(0, 1, 8'($urandom), 0);
            ndone += int'(ifc.o_frame_done);
        end
        cycle(1, 1, 8'h5A, 0);
        vectors++;
        if (ifc.o_row_wen !== 1'b0 || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL abort_discard: got %h want %h", dut_vec(), model_vec());
        end
        for (int i = 0; i < NPIX; i++) begin
            cycle(0, 1, 8'($urandom), 0);
            ndone += int'(ifc.o_frame_done);
            vectors++;
            if (dut_vec() !== model_vec() || (i == 0 && ifc.o_row_sync !== 1'b1)) begin
                miscompares++;
                $display("FAIL abort_restart pix%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (ndone != 1) begin
            miscompares++;
            $display("FAIL abort_done_count: got %0d want 1", ndone);
        end
    endtask

    task automatic test_reset_mid_stream();
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, 8'($urandom), 0);
        cycle(0, 1, 8'hFF, 1);
        vectors++;
        if (dut_vec() !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got %h want 0", dut_vec());
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 8'($urandom), 0);
            vectors++;
            if (ifc.o_row_wen !== 1'b0 || ifc.o_ready !== 1'b0 || dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL reset_ignore cyc%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    // Second frame starts in the DONE cycle, straight after the last pixel.
    task automatic test_back_to_back();
        int fw1, fw2;
        run_frame("b2b_first", fw1);
        run_frame("b2b_second", fw2);
        vectors++;
        if (fw1 != 19 || fw2 != 19) begin
            miscompares++;
            $display("FAIL b2b_window_timing: got %0d/%0d want 19/19", fw1, fw2);
        end
    endtask

    initial begin
        reset_os = 1'b1;
        ifc.i_frame_start = 1'b0;
        ifc.i_pixel_valid = 1'b0;
        ifc.i_pixel = '0;
        test_reset();
        test_idle_pixels();
        test_continuous_frame();
        gapped_frame("valid_toggle", 0);
        gapped_frame("random_gaps", 1);
        test_abort();
        test_reset_mid_stream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
